// File: rtl/mac_dot_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : mac_dot_sequencer_if
// Brief   : Bundles the command, operand stream, MAC drive and result port
//           signals of the dot-product sequencer.
//           slave  = the sequencer's view
//           master = the surrounding system (command source, operand source,
//                    MAC and result consumer)
// Revision: 1.0 - initial release
// ============================================================================
interface mac_dot_sequencer_if #(
    parameter int LEN_W = 8
) ();

    // Command
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;

    // Operand stream
    logic             op_valid;
    logic             op_ready;
    logic [7:0]       op_a;
    logic [7:0]       op_b;

    // MAC drive and readback
    logic             mac_reset;
    logic [7:0]       mac_in1;
    logic [7:0]       mac_in2;
    logic             mac_out_hl;
    logic [15:0]      mac_out;
    logic             mac_error;

    // Result port
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_error;

    modport slave (
        input  start, len, op_valid, op_a, op_b, mac_out, mac_error, res_ready,
        output busy, op_ready, mac_reset, mac_in1, mac_in2, mac_out_hl,
               res_valid, res_data, res_error
    );

    modport master (
        output start, len, op_valid, op_a, op_b, mac_out, mac_error, res_ready,
        input  busy, op_ready, mac_reset, mac_in1, mac_in2, mac_out_hl,
               res_valid, res_data, res_error
    );

endinterface
`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mac_dot_sequencer
// Brief   : Clears the fp8 MAC, streams N operand pairs into it, reads the
//           32-bit accumulator back as two 16-bit halves and hands the result
//           plus a sticky error flag to a valid/ready consumer.
// Revision: 1.0 - initial release
// ============================================================================
module mac_dot_sequencer #(
    parameter int LEN_W = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mac_dot_sequencer_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FEED    = 3'd1;
    localparam logic [2:0] c_ST_READ_LO = 3'd2;
    localparam logic [2:0] c_ST_READ_HI = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    localparam logic [LEN_W-1:0] c_ZERO = '0;
    localparam logic [LEN_W-1:0] c_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_count;
    logic             r_err;
    logic [15:0]      r_lo;
    logic [31:0]      r_res_data;
    logic             r_res_error;

    logic             w_feed;
    logic             w_accept;

    assign w_feed   = (r_state == c_ST_FEED);
    assign w_accept = w_feed & bus.op_valid;

    // Sequencing FSM: counts accepted pairs, then reads back low and high halves
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_count     <= c_ZERO;
            r_err       <= 1'b0;
            r_lo        <= 16'h0000;
            r_res_data  <= 32'h0000_0000;
            r_res_error <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_count <= bus.len;
                        r_err   <= 1'b0;
                        r_state <= (bus.len != c_ZERO) ? c_ST_FEED : c_ST_READ_LO;
                    end
                end
                c_ST_FEED: begin
                    // A bubble holds everything; the MAC sees a zero product
                    if (bus.op_valid) begin
                        r_err   <= r_err | bus.mac_error;
                        r_count <= r_count - c_ONE;
                        if (r_count == c_ONE) begin
                            r_state <= c_ST_READ_LO;
                        end
                    end
                end
                c_ST_READ_LO: begin
                    r_lo    <= bus.mac_out;
                    r_state <= c_ST_READ_HI;
                end
                c_ST_READ_HI: begin
                    r_res_data  <= {bus.mac_out, r_lo};
                    r_res_error <= r_err;
                    r_state     <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    // A start in this cycle is dropped: only IDLE takes commands
                    if (bus.res_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state register; operands pass through only on accept
    always_comb begin
        bus.busy       = (r_state != c_ST_IDLE);
        bus.op_ready   = w_feed;
        bus.mac_reset  = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
        bus.mac_in1    = w_accept ? bus.op_a : 8'h00;
        bus.mac_in2    = w_accept ? bus.op_b : 8'h00;
        bus.mac_out_hl = (r_state == c_ST_READ_HI);
        bus.res_valid  = (r_state == c_ST_DONE);
        bus.res_data   = r_res_data;
        bus.res_error  = r_res_error;
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_dot_sequencer
// Brief   : Directed bench for mac_dot_sequencer with a behavioural MAC stub.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_dot_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mac_dot_sequencer_if #(.LEN_W(8)) bus ();

    mac_dot_sequencer #(.LEN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub MAC: adds the concatenated operands as a 16-bit value
    logic [31:0] r_acc;
    always_ff @(posedge clk) begin
        r_acc <= bus.mac_reset ? 32'h0 : r_acc + {16'h0, bus.mac_in1, bus.mac_in2};
    end
    assign bus.mac_out   = bus.mac_out_hl ? r_acc[31:16] : r_acc[15:0];
    assign bus.mac_error = (bus.mac_in1 == 8'hFF);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.op_valid  = 1'b0;
        bus.op_a      = 8'h00;
        bus.op_b      = 8'h00;
        bus.res_ready = 1'b1;

        // ---- Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mid();
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_op_ready",   32'(bus.op_ready),   32'd0);
        chk("rst_mac_reset",  32'(bus.mac_reset),  32'd1);
        chk("rst_mac_in1",    32'(bus.mac_in1),    32'd0);
        chk("rst_mac_in2",    32'(bus.mac_in2),    32'd0);
        chk("rst_out_hl",     32'(bus.mac_out_hl), 32'd0);
        chk("rst_res_valid",  32'(bus.res_valid),  32'd0);
        chk("rst_res_data",   bus.res_data,        32'd0);
        chk("rst_res_error",  32'(bus.res_error),  32'd0);

        // ---- len=3, back-to-back pairs
        tick(); bus.start = 1'b1; bus.len = 8'd3;                        // cycle 0
        mid();  chk("t1_c0_busy", 32'(bus.busy), 32'd0);
        tick(); bus.start = 1'b0; bus.op_valid = 1'b1;                   // cycle 1
        bus.op_a = 8'h01; bus.op_b = 8'h02;
        mid();  chk("t1_c1_op_ready", 32'(bus.op_ready), 32'd1);
                chk("t1_c1_mac_in1",  32'(bus.mac_in1),  32'h01);
                chk("t1_c1_mac_in2",  32'(bus.mac_in2),  32'h02);
                chk("t1_c1_mac_reset", 32'(bus.mac_reset), 32'd0);
        tick(); bus.op_a = 8'h03; bus.op_b = 8'h04;                      // cycle 2
        tick(); bus.op_a = 8'h05; bus.op_b = 8'h06;                      // cycle 3
        mid();  chk("t1_c3_busy", 32'(bus.busy), 32'd1);
        tick(); bus.op_valid = 1'b0;                                     // cycle 4
        mid();  chk("t1_c4_op_ready", 32'(bus.op_ready), 32'd0);
                chk("t1_c4_out_hl",   32'(bus.mac_out_hl), 32'd0);
                chk("t1_c4_mac_reset", 32'(bus.mac_reset), 32'd0);
        tick();                                                          // cycle 5
        mid();  chk("t1_c5_out_hl",    32'(bus.mac_out_hl), 32'd1);
                chk("t1_c5_res_valid", 32'(bus.res_valid),  32'd0);
        tick();                                                          // cycle 6
        mid();  chk("t1_c6_res_valid", 32'(bus.res_valid), 32'd1);
                chk("t1_c6_res_data",  bus.res_data,       32'h0000_090C);
                chk("t1_c6_res_error", 32'(bus.res_error), 32'd0);
                chk("t1_c6_mac_reset", 32'(bus.mac_reset), 32'd1);
        tick();                                                          // cycle 7
        mid();  chk("t1_c7_busy",      32'(bus.busy),      32'd0);
                chk("t1_c7_res_valid", 32'(bus.res_valid), 32'd0);

        // ---- len=2 with two bubble cycles between pairs
        tick(); bus.start = 1'b1; bus.len = 8'd2;                        // cycle 0
        tick(); bus.start = 1'b0; bus.op_valid = 1'b1;                   // cycle 1
        bus.op_a = 8'h80; bus.op_b = 8'h00;
        tick(); bus.op_valid = 1'b0; bus.op_a = 8'hAA; bus.op_b = 8'h55; // cycle 2
        mid();  chk("t2_c2_bub_in1",   32'(bus.mac_in1),  32'h00);
                chk("t2_c2_bub_in2",   32'(bus.mac_in2),  32'h00);
                chk("t2_c2_op_ready",  32'(bus.op_ready), 32'd1);
        tick();                                                          // cycle 3
        mid();  chk("t2_c3_bub_in1",   32'(bus.mac_in1),  32'h00);
                chk("t2_c3_busy",      32'(bus.busy),     32'd1);
        tick(); bus.op_valid = 1'b1; bus.op_a = 8'h80; bus.op_b = 8'h00; // cycle 4
        mid();  chk("t2_c4_mac_in1",   32'(bus.mac_in1),  32'h80);
        tick(); bus.op_valid = 1'b0;                                     // cycle 5
        mid();  chk("t2_c5_op_ready",  32'(bus.op_ready), 32'd0);
        tick();                                                          // cycle 6
        mid();  chk("t2_c6_res_valid", 32'(bus.res_valid), 32'd0);
        tick();                                                          // cycle 7
        mid();  chk("t2_c7_res_valid", 32'(bus.res_valid), 32'd1);
                chk("t2_c7_res_data",  bus.res_data,       32'h0001_0000);

        // ---- len=0, then len=1 with an error operand
        tick(); bus.start = 1'b1; bus.len = 8'd0;                        // cycle 0
        tick(); bus.start = 1'b0;                                        // cycle 1
        mid();  chk("t3_c1_busy",      32'(bus.busy),     32'd1);
                chk("t3_c1_op_ready",  32'(bus.op_ready), 32'd0);
        tick();                                                          // cycle 2
        mid();  chk("t3_c2_res_valid", 32'(bus.res_valid), 32'd0);
        tick();                                                          // cycle 3
        mid();  chk("t3_c3_res_valid", 32'(bus.res_valid), 32'd1);
                chk("t3_c3_res_data",  bus.res_data,       32'h0);
        tick(); bus.start = 1'b1; bus.len = 8'd1;                        // cycle 0
        tick(); bus.start = 1'b0; bus.op_valid = 1'b1;                   // cycle 1
        bus.op_a = 8'hFF; bus.op_b = 8'h01;
        tick(); bus.op_valid = 1'b0;                                     // cycle 2
        tick();                                                          // cycle 3
        tick();                                                          // cycle 4
        mid();  chk("t3b_res_valid", 32'(bus.res_valid), 32'd1);
                chk("t3b_res_data",  bus.res_data,       32'h0000_FF01);
                chk("t3b_res_error", 32'(bus.res_error), 32'd1);

        // ---- Back-pressure in DONE with start pulsing
        tick(); bus.start = 1'b1; bus.len = 8'd1; bus.res_ready = 1'b0;  // cycle 0
        tick(); bus.start = 1'b0; bus.op_valid = 1'b1;                   // cycle 1
        bus.op_a = 8'h10; bus.op_b = 8'h20;
        tick(); bus.op_valid = 1'b0;                                     // cycle 2
        tick();                                                          // cycle 3
        tick();                                                          // cycle 4
        mid();  chk("t4_res_valid", 32'(bus.res_valid), 32'd1);
                chk("t4_res_data",  bus.res_data,       32'h0000_1020);
                chk("t4_res_error", 32'(bus.res_error), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(); bus.start = ~bus.start; bus.len = 8'd5;
            mid();  chk("t4_hold_valid", 32'(bus.res_valid), 32'd1);
                    chk("t4_hold_data",  bus.res_data,       32'h0000_1020);
                    chk("t4_hold_busy",  32'(bus.busy),      32'd1);
        end
        tick(); bus.start = 1'b1; bus.res_ready = 1'b1;
        mid();  chk("t4_release_valid", 32'(bus.res_valid), 32'd1);
        tick(); bus.start = 1'b0;
        mid();  chk("t4_idle_busy",  32'(bus.busy), 32'd0);
        tick();
        mid();  chk("t4_idle_busy2", 32'(bus.busy), 32'd0);

        // ---- Reset in FEED after one of three pairs
        tick(); bus.start = 1'b1; bus.len = 8'd3;                        // cycle 0
        tick(); bus.start = 1'b0; bus.op_valid = 1'b1;                   // cycle 1
        bus.op_a = 8'h01; bus.op_b = 8'h01;
        tick(); bus.op_a = 8'h07; bus.op_b = 8'h07; reset = 1'b1;        // cycle 2
        tick(); reset = 1'b0; bus.op_valid = 1'b0;                       // cycle 3
        mid();  chk("t5_busy",       32'(bus.busy),       32'd0);
                chk("t5_op_ready",   32'(bus.op_ready),   32'd0);
                chk("t5_mac_reset",  32'(bus.mac_reset),  32'd1);
                chk("t5_res_valid",  32'(bus.res_valid),  32'd0);
                chk("t5_res_data",   bus.res_data,        32'h0);
                chk("t5_res_error",  32'(bus.res_error),  32'd0);
                chk("t5_mac_in1",    32'(bus.mac_in1),    32'd0);
                chk("t5_out_hl",     32'(bus.mac_out_hl), 32'd0);
        tick(); bus.start = 1'b1; bus.len = 8'd1;                        // cycle 0
        tick(); bus.start = 1'b0; bus.op_valid = 1'b1;                   // cycle 1
        bus.op_a = 8'h02; bus.op_b = 8'h02;
        tick(); bus.op_valid = 1'b0;                                     // cycle 2
        tick();                                                          // cycle 3
        tick();                                                          // cycle 4
        mid();  chk("t5b_res_valid", 32'(bus.res_valid), 32'd1);
                chk("t5b_res_data",  bus.res_data,       32'h0000_0202);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Control and buffering stage directly upstream of the fp8 multiply-accumulate unit. It accepts a dot-product command (length N), streams N operand pairs from a valid/ready source into the MAC, clears the accumulator beforehand, then reads the 32-bit accumulator out as two 16-bit halves via the MAC's high/low select. The assembled result and a sticky overflow flag go to a downstream consumer over a valid/ready port. The MAC itself is unchanged.

## Interface
- LEN_W, 8, width of the dot-product length field (max N = 2^LEN_W - 1)
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe, honoured only in IDLE
- len  in  LEN_W  number of operand pairs N; sampled with start
- busy  out  1  high whenever state is not IDLE
- op_valid  in  1  operand pair available
- op_ready  out  1  sequencer accepts operand pair this cycle
- op_a, op_b  in  8  fp8 operands (1 sign, 4 exponent, 3 mantissa)
- mac_reset  out  1  drives MAC reset; 1 clears accumulator at next edge
- mac_in1, mac_in2  out  8  drive MAC input1/input2
- mac_out_hl  out  1  drives MAC out_HL; 0 = low half, 1 = high half
- mac_out  in  16  MAC out
- mac_error  in  1  MAC error (combinational for current operands)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  32  {high half, low half} of final accumulator
- res_error  out  1  OR of mac_error over all accepted pairs

## Operation
- States: IDLE, FEED, READ_LO, READ_HI, DONE.
- IDLE: mac_reset=1, mac_in1/2=0, op_ready=0. start=1: latch count=len, clear error flag; next state FEED if len!=0, else READ_LO.
- FEED: mac_reset=0, op_ready=1. op_valid=1: mac_in1=op_a, mac_in2=op_b, error |= mac_error, count -= 1; if count was 1, next state READ_LO. op_valid=0: mac_in1/2=8'h00 (bubble; adds zero), state and count hold.
- READ_LO: mac_reset=0, mac_in=0, mac_out_hl=0; capture mac_out into lo register; next READ_HI.
- READ_HI: mac_out_hl=1, mac_in=0; register res_data={mac_out, lo}, res_error=error flag; next DONE.
- DONE: res_valid=1, mac_reset=1, mac_in=0; res_data/res_error stable. res_ready=1: next IDLE.
- mac_in1/2 are 8'h00 in every state except FEED with op_valid=1; 8'h00 x 8'h00 is a zero product, so the accumulator holds.
- mac_out_hl=0 in all states except READ_HI.
- start outside IDLE is ignored; len is not re-sampled.
- Counter is LEN_W bits, never wraps (exit at count 1).

## Timing
- Reset values: state IDLE, busy 0, op_ready 0, mac_reset 1, mac_in1/2 0, mac_out_hl 0, res_valid 0, res_data 0, res_error 0, count 0.
- Reset mid-operation: next edge returns to IDLE with the values above. The accumulator clears on the following edge via mac_reset. Any in-flight result is dropped.
- Latency: start at cycle 0, N back-to-back pairs accepted at cycles 1..N, READ_LO at N+1, READ_HI at N+2, res_valid first high at N+3. Each bubble adds 1 cycle. len=0 gives res_valid at cycle 3 with res_data=0.
- The product of the pair accepted at cycle k enters the accumulator at the end of cycle k. The last product is visible in READ_LO.
- res_valid holds until res_ready. A start in the same cycle as the DONE->IDLE transition is ignored. The earliest new command is the cycle after.
- The accumulator is cleared only by the IDLE/DONE mac_reset, never within FEED.

## Test plan
- Bench uses a stub MAC: acc <= reset ? 0 : acc + {mac_in1, mac_in2}; out = hl ? acc[31:16] : acc[15:0]; error = (mac_in1==8'hFF).
- len=3, pairs (01,02),(03,04),(05,06) back-to-back, res_ready=1 -> res_valid at cycle 6, res_data=32'h0000_090C, res_error=0, busy falls at cycle 7.
- len=2, op_valid low for 2 cycles between pairs (80,00),(80,00) -> bubbles drive 00/00, res_valid at cycle 7, res_data=32'h0001_0000 (carry into high half).
- len=0 -> res_valid at cycle 3, res_data=0; then len=1 pair (FF,01) -> res_error=1, res_data=32'h0000_FF01 (no stale accumulation).
- Hold res_ready=0 for 5 cycles in DONE with start pulsing -> res_valid and res_data stable, no new command taken; res_ready=1 -> IDLE next cycle.
- Assert reset in FEED after 1 of 3 pairs -> IDLE next edge with all reset values, op_ready=0. A fresh len=1 pair (02,02) then yields 32'h0000_0202.
